// File: rtl/alu_sequencer.sv
// Sequencer driving a combinational ALU: one-step ADD/SUB/AND/PASS plus multi-step SHL and MUL
// built from repeated ALU adds, with valid/ready handshakes on request and result.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  n,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_c,
  output logic        alu_en_bar,
  input  logic [15:0] alu_val,
  input  logic        alu_z,
  input  logic        alu_lt,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result,
  output logic        z,
  output logic        lt
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpShl = 3'd3;
  localparam logic [2:0] OpMul = 3'd4;

  // Control word {ex,nx,ey,ny,f,no}
  localparam logic [5:0] CtlAdd  = 6'b101010;
  localparam logic [5:0] CtlSub  = 6'b111011;
  localparam logic [5:0] CtlAnd  = 6'b101000;
  localparam logic [5:0] CtlPass = 6'b100010;
  localparam logic [5:0] CtlZero = 6'b000010;

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  n_q, n_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] result_q, result_d;
  logic        z_q, z_d;
  logic        lt_q, lt_d;

  logic        req_multi;
  logic [3:0]  req_steps;

  // SHL and MUL take n steps; everything else, including n=0, is a single step.
  assign req_multi = (op == OpShl) || (op == OpMul);
  assign req_steps = (req_multi && (n != 4'd0)) ? n : 4'd1;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      z_q      <= z_d;
      lt_q     <= lt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    z_d      = z_q;
    lt_d     = lt_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          n_d     = n;
          acc_d   = (op == OpShl) ? a : 16'd0;
          rem_d   = req_steps;
          state_d = StStep;
        end
      end
      StStep: begin
        acc_d = alu_val;
        if (rem_q == 4'd1) begin
          result_d = alu_val;
          z_d      = alu_z;
          lt_d     = alu_lt;
          state_d  = StDone;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU drive depends on registered state only.
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_c      = '0;
    alu_en_bar = 1'b1;
    if (state_q == StStep) begin
      alu_en_bar = 1'b0;
      case (op_q)
        OpAdd: begin
          alu_x = a_q;
          alu_y = b_q;
          alu_c = CtlAdd;
        end
        OpSub: begin
          alu_x = a_q;
          alu_y = b_q;
          alu_c = CtlSub;
        end
        OpAnd: begin
          alu_x = a_q;
          alu_y = b_q;
          alu_c = CtlAnd;
        end
        OpShl: begin
          if (n_q == 4'd0) begin
            alu_x = a_q;
            alu_c = CtlPass;
          end else begin
            alu_x = acc_q;
            alu_y = acc_q;
            alu_c = CtlAdd;
          end
        end
        OpMul: begin
          if (n_q == 4'd0) begin
            alu_c = CtlZero;
          end else begin
            alu_x = acc_q;
            alu_y = a_q;
            alu_c = CtlAdd;
          end
        end
        default: begin
          alu_x = a_q;
          alu_c = CtlPass;
        end
      endcase
    end
  end

  assign op_ready  = (state_q == StIdle);
  assign res_valid = (state_q == StDone);
  assign result    = result_q;
  assign z         = z_q;
  assign lt        = lt_q;

endmodule
